// File: rtl/pc_stack_sequencer_pkg.sv
// Shared types and constants for the PC/stack push-and-vector sequencer.
package pc_stack_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_PCH = 3'd1,
        ST_PUSH_PCL = 3'd2,
        ST_PUSH_P   = 3'd3,
        ST_VEC_LO   = 3'd4,
        ST_VEC_HI   = 3'd5,
        ST_JLOAD    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        KIND_JSR = 2'd0,
        KIND_IRQ = 2'd1,
        KIND_NMI = 2'd2,
        KIND_BRK = 2'd3
    } kind_e;

    localparam logic [7:0] STACK_PAGE = 8'h01;

    // Status-byte bit positions touched when P is pushed.
    localparam int P_BIT_B = 4;
    localparam int P_BIT_5 = 5;

    // Status byte as it lands on the stack: bit5 always set, B set only for BRK.
    function automatic logic [7:0] push_p_byte(input logic [7:0] p, input logic is_brk);
        logic [7:0] r;
        r          = p;
        r[P_BIT_5] = 1'b1;
        r[P_BIT_B] = is_brk;
        return r;
    endfunction

endpackage

// File: rtl/pc_stack_sequencer_stack_addr_gen.sv
// Stack address former: page-1 address from sp and the post-push sp (mod 256).
module stack_addr_gen
    import pc_stack_sequencer_pkg::*;
(
    input  logic [7:0]  sp_i,
    output logic [15:0] addr_o,
    output logic [7:0]  sp_dec_o
);

    assign addr_o   = {STACK_PAGE, sp_i};
    assign sp_dec_o = sp_i - 8'd1;

endmodule

// File: rtl/pc_stack_sequencer.sv
// PC/stack sequencer: pushes return PC (and P for interrupts), then loads the
// new PC from a vector or the JSR target.
// Optional feature macro: PC_STACK_NMI_HIJACK_EN -- an NMI arriving during the
// push phase of an IRQ/BRK redirects that sequence to the NMI vector.
module pc_stack_sequencer
    import pc_stack_sequencer_pkg::*;
#(
    parameter logic [15:0] IRQ_VEC = 16'hFFFE,
    parameter logic [15:0] NMI_VEC = 16'hFFFA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        req_valid,
    input  logic [1:0]  req_kind,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  sp_in,
    input  logic [15:0] jsr_target,
    input  logic        nmi_pending,
    input  logic [7:0]  din,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        busy,
    output logic [15:0] pc_out,
    output logic        pc_load,
    output logic [7:0]  sp_out,
    output logic        i_set
);

    state_e      state_q, state_d;
    kind_e       kind_q;
    logic [15:0] pc_q;
    logic [7:0]  p_q;
    logic [7:0]  sp_q;
    logic [15:0] jsr_q;
    logic [7:0]  vec_lo_q;

    logic [15:0] stack_addr;
    logic [7:0]  sp_dec;
    logic        in_push;
    logic        use_nmi_vec;
    logic [15:0] vec_addr;

    stack_addr_gen u_stack_addr_gen (
        .sp_i     (sp_q),
        .addr_o   (stack_addr),
        .sp_dec_o (sp_dec)
    );

    assign in_push = (state_q == ST_PUSH_PCH) || (state_q == ST_PUSH_PCL) ||
                     (state_q == ST_PUSH_P);

`ifdef PC_STACK_NMI_HIJACK_EN
    logic hijack_q, hijack_d;

    // Hijack flag register: remembers an NMI seen while pushing for IRQ/BRK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hijack_q <= 1'b0;
        else        hijack_q <= hijack_d;
    end

    // Hijack next-state: cleared while idle, set by NMI during an IRQ/BRK push.
    always_comb begin
        hijack_d = hijack_q;
        if (ce) begin
            if (state_q == ST_IDLE) begin
                hijack_d = 1'b0;
            end else if (in_push && nmi_pending &&
                         ((kind_q == KIND_IRQ) || (kind_q == KIND_BRK))) begin
                hijack_d = 1'b1;
            end
        end
    end

    assign use_nmi_vec = (kind_q == KIND_NMI) || hijack_q;
`else
    logic unused_nmi_pending;
    assign unused_nmi_pending = nmi_pending;
    assign use_nmi_vec        = (kind_q == KIND_NMI);
`endif

    assign vec_addr = use_nmi_vec ? NMI_VEC : IRQ_VEC;

    // State register; reset aborts any sequence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; nothing moves unless ce is high.
    always_comb begin
        state_d = state_q;
        if (ce) begin
            unique case (state_q)
                ST_IDLE:     if (req_valid) state_d = ST_PUSH_PCH;
                ST_PUSH_PCH: state_d = ST_PUSH_PCL;
                ST_PUSH_PCL: state_d = (kind_q == KIND_JSR) ? ST_JLOAD : ST_PUSH_P;
                ST_PUSH_P:   state_d = ST_VEC_LO;
                ST_VEC_LO:   state_d = ST_VEC_HI;
                ST_VEC_HI:   state_d = ST_IDLE;
                ST_JLOAD:    state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Request context, stack pointer and vector low byte; outputs gate these by state.
    always_ff @(posedge clk) begin
        if (ce) begin
            if ((state_q == ST_IDLE) && req_valid) begin
                pc_q   <= pc_in;
                p_q    <= p_in;
                sp_q   <= sp_in;
                kind_q <= kind_e'(req_kind);
                jsr_q  <= jsr_target;
            end else if (in_push) begin
                sp_q <= sp_dec;
            end
            if (state_q == ST_VEC_LO) vec_lo_q <= din;
        end
    end

    // Output decode: everything is zero in IDLE, strobes qualified by ce.
    always_comb begin
        addr    = 16'h0000;
        dout    = 8'h00;
        we      = 1'b0;
        pc_out  = 16'h0000;
        pc_load = 1'b0;
        sp_out  = 8'h00;
        i_set   = 1'b0;
        busy    = (state_q != ST_IDLE);
        unique case (state_q)
            ST_PUSH_PCH: begin
                addr = stack_addr;
                dout = pc_q[15:8];
                we   = ce;
            end
            ST_PUSH_PCL: begin
                addr = stack_addr;
                dout = pc_q[7:0];
                we   = ce;
            end
            ST_PUSH_P: begin
                addr = stack_addr;
                dout = push_p_byte(p_q, kind_q == KIND_BRK);
                we   = ce;
            end
            ST_VEC_LO: begin
                addr = vec_addr;
            end
            ST_VEC_HI: begin
                addr    = vec_addr + 16'd1;
                pc_out  = {din, vec_lo_q};
                pc_load = ce;
                i_set   = ce;
                sp_out  = sp_q;
            end
            ST_JLOAD: begin
                pc_out  = jsr_q;
                pc_load = ce;
                sp_out  = sp_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Self-checking bench for pc_stack_sequencer with a write/PC-load scoreboard.
module tb_pc_stack_sequencer;

    localparam logic [1:0] K_JSR = 2'd0;
    localparam logic [1:0] K_IRQ = 2'd1;
    localparam logic [1:0] K_NMI = 2'd2;
    localparam logic [1:0] K_BRK = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        req_valid;
    logic [1:0]  req_kind;
    logic [15:0] pc_in;
    logic [7:0]  p_in;
    logic [7:0]  sp_in;
    logic [15:0] jsr_target;
    logic        nmi_pending;
    logic [7:0]  din;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic        busy;
    logic [15:0] pc_out;
    logic        pc_load;
    logic [7:0]  sp_out;
    logic        i_set;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  sp;
        logic        iset;
        logic [15:0] vaddr;
        logic [7:0]  lat;
    } pc_exp_t;

    logic [23:0] exp_wr[$];
    pc_exp_t     exp_pc[$];

    int vectors = 0;
    int errs    = 0;
    int ce_cnt  = 0;
    bit armed   = 0;

    pc_stack_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .req_valid  (req_valid),
        .req_kind   (req_kind),
        .pc_in      (pc_in),
        .p_in       (p_in),
        .sp_in      (sp_in),
        .jsr_target (jsr_target),
        .nmi_pending(nmi_pending),
        .din        (din),
        .addr       (addr),
        .dout       (dout),
        .we         (we),
        .busy       (busy),
        .pc_out     (pc_out),
        .pc_load    (pc_load),
        .sp_out     (sp_out),
        .i_set      (i_set)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'hFFFE: return 8'h00;
            16'hFFFF: return 8'h80;
            16'hFFFA: return 8'h34;
            16'hFFFB: return 8'h12;
            default:  return 8'hEE;
        endcase
    endfunction

    assign din = rom(addr);

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        logic [23:0] w;
        pc_exp_t     e;
        if (!rst_n) begin
            armed = 0;
        end else begin
            if (we === 1'b1) begin
                vectors++;
                if (exp_wr.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_write addr=%h dout=%h ce=%b", addr, dout, ce);
                end else begin
                    w = exp_wr.pop_front();
                    if ({addr, dout} !== w || ce !== 1'b1) begin
                        errs++;
                        $display("FAIL stack_write got %h:%h ce=%b required %h:%h ce=1",
                                 addr, dout, ce, w[23:8], w[7:0]);
                    end
                end
            end
            if (i_set === 1'b1 && pc_load !== 1'b1) begin
                vectors++;
                errs++;
                $display("FAIL i_set_without_pc_load i_set=%b pc_load=%b", i_set, pc_load);
            end
            if (armed && ce === 1'b1) ce_cnt++;
            if (pc_load === 1'b1) begin
                vectors++;
                if (exp_pc.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_pc_load pc_out=%h", pc_out);
                end else begin
                    e = exp_pc.pop_front();
                    if (pc_out !== e.pc || sp_out !== e.sp || i_set !== e.iset ||
                        addr !== e.vaddr || ce_cnt != int'(e.lat)) begin
                        errs++;
                        $display("FAIL pc_load got pc=%h sp=%h i=%b addr=%h lat=%0d required pc=%h sp=%h i=%b addr=%h lat=%0d",
                                 pc_out, sp_out, i_set, addr, ce_cnt,
                                 e.pc, e.sp, e.iset, e.vaddr, e.lat);
                    end
                end
                armed = 0;
            end
            if (busy === 1'b0 && req_valid === 1'b1 && ce === 1'b1) begin
                armed  = 1;
                ce_cnt = 0;
            end
        end
    end

    // Present a request and push its expected bus activity.
    task automatic start(input logic [1:0] k, input logic [15:0] pc, input logic [7:0] p,
                         input logic [7:0] sp, input logic [15:0] tgt, input bit nmi_vec);
        logic [7:0]  s1, s2, pb;
        logic [15:0] v;
        pc_exp_t     e;
        s1 = sp - 8'd1;
        s2 = sp - 8'd2;
        exp_wr.push_back({8'h01, sp, pc[15:8]});
        exp_wr.push_back({8'h01, s1, pc[7:0]});
        if (k == K_JSR) begin
            e = '{pc: tgt, sp: s2, iset: 1'b0, vaddr: 16'h0000, lat: 8'd3};
        end else begin
            pb    = p | 8'h20;
            pb[4] = (k == K_BRK);
            exp_wr.push_back({8'h01, s2, pb});
            v = nmi_vec ? 16'hFFFA : 16'hFFFE;
            e = '{pc: {rom(v + 16'd1), rom(v)}, sp: sp - 8'd3, iset: 1'b1,
                  vaddr: v + 16'd1, lat: 8'd5};
        end
        exp_pc.push_back(e);
        req_kind   = k;
        pc_in      = pc;
        p_in       = p;
        sp_in      = sp;
        jsr_target = tgt;
        req_valid  = 1'b1;
        ce         = 1'b1;
    endtask

    // Accept the pending request and run until the sequencer is idle again.
    task automatic run(input bit toggle);
        int n;
        n = 0;
        @(posedge clk); #2;
        req_valid = 1'b0;
        while (busy === 1'b1 && n < 60) begin
            if (toggle) ce = ~ce;
            @(posedge clk); #2;
            n++;
        end
        ce = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({busy, we, pc_load, i_set} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_strobes busy/we/pc_load/i_set=%b required 0000",
                     {busy, we, pc_load, i_set});
        end
        vectors++;
        if (addr !== 16'h0 || dout !== 8'h0) begin
            errs++;
            $display("FAIL reset_bus addr=%h dout=%h required 0000/00", addr, dout);
        end
        vectors++;
        if (pc_out !== 16'h0 || sp_out !== 8'h0) begin
            errs++;
            $display("FAIL reset_pc pc_out=%h sp_out=%h required 0000/00", pc_out, sp_out);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_irq();
        start(K_IRQ, 16'h1234, 8'h81, 8'hFD, 16'h0000, 1'b0);
        run(1'b0);
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL irq_drain busy=%b wr_left=%0d pc_left=%0d required 0/0/0",
                     busy, exp_wr.size(), exp_pc.size());
        end
    endtask

    task automatic test_jsr_wrap();
        start(K_JSR, 16'hC002, 8'h55, 8'h01, 16'hD000, 1'b0);
        run(1'b0);
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL jsr_drain busy=%b wr_left=%0d pc_left=%0d required 0/0/0",
                     busy, exp_wr.size(), exp_pc.size());
        end
    endtask

    task automatic test_brk();
        start(K_BRK, 16'h0400, 8'h00, 8'h00, 16'h0000, 1'b0);
        run(1'b0);
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL brk_drain busy=%b wr_left=%0d pc_left=%0d required 0/0/0",
                     busy, exp_wr.size(), exp_pc.size());
        end
    endtask

    task automatic test_ce_toggle();
        start(K_IRQ, 16'h1234, 8'h81, 8'hFD, 16'h0000, 1'b0);
        run(1'b1);
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL ce_toggle_drain busy=%b wr_left=%0d pc_left=%0d required 0/0/0",
                     busy, exp_wr.size(), exp_pc.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_wr.push_back({16'h01F0, 8'h55});
        req_kind  = K_IRQ;
        pc_in     = 16'h5566;
        p_in      = 8'h00;
        sp_in     = 8'hF0;
        req_valid = 1'b1;
        ce        = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || we !== 1'b0 || pc_load !== 1'b0 || addr !== 16'h0) begin
            errs++;
            $display("FAIL reset_mid busy=%b we=%b pc_load=%b addr=%h required 0/0/0/0000",
                     busy, we, pc_load, addr);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0) begin
            errs++;
            $display("FAIL reset_mid_idle busy=%b wr_left=%0d required 0/0", busy, exp_wr.size());
        end
        start(K_NMI, 16'hABCD, 8'h04, 8'h80, 16'h0000, 1'b1);
        run(1'b0);
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL nmi_after_reset_drain busy=%b wr_left=%0d pc_left=%0d required 0/0/0",
                     busy, exp_wr.size(), exp_pc.size());
        end
    endtask

    task automatic test_hijack();
        int  n;
        bit  hij;
`ifdef PC_STACK_NMI_HIJACK_EN
        hij = 1'b1;
`else
        hij = 1'b0;
`endif
        start(K_IRQ, 16'h2000, 8'h00, 8'hC0, 16'h0000, hij);
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(posedge clk); #2;
        nmi_pending = 1'b1;
        @(posedge clk); #2;
        nmi_pending = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL hijack_drain busy=%b wr_left=%0d pc_left=%0d required 0/0/0",
                     busy, exp_wr.size(), exp_pc.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start(K_JSR, 16'h0300, 8'h00, 8'h10, 16'h4000, 1'b0);
        @(posedge clk); #2;
        // A second request held high while busy must be ignored.
        req_kind   = K_IRQ;
        pc_in      = 16'hFFFF;
        sp_in      = 8'h00;
        jsr_target = 16'h1111;
        n = 0;
        while (pc_load !== 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        req_valid = 1'b0;
        vectors++;
        if (pc_load !== 1'b1) begin
            errs++;
            $display("FAIL b2b_timeout pc_load=%b required 1", pc_load);
        end
        @(posedge clk); #2;
        vectors++;
        if (busy !== 1'b0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL b2b_ignore busy=%b pc_left=%0d required 0/0", busy, exp_pc.size());
        end
        start(K_BRK, 16'h8765, 8'hCF, 8'h02, 16'h0000, 1'b0);
        run(1'b0);
        vectors++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_pc.size() != 0) begin
            errs++;
            $display("FAIL b2b_brk_drain busy=%b wr_left=%0d pc_left=%0d required 0/0/0",
                     busy, exp_wr.size(), exp_pc.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ce          = 1'b1;
        req_valid   = 1'b0;
        req_kind    = 2'd0;
        pc_in       = 16'h0;
        p_in        = 8'h0;
        sp_in       = 8'h0;
        jsr_target  = 16'h0;
        nmi_pending = 1'b0;
        test_reset();
        test_irq();
        test_jsr_wrap();
        test_brk();
        test_ce_toggle();
        test_reset_mid();
        test_hijack();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
